binary_maxpool_2x2: RTL

//  Downstream stage of the XNOR convolution core. Consumes the thresholded 1-bit

---
 rtl/binary_maxpool_2x2_if.sv | 22 ++
 rtl/binary_maxpool_2x2.sv | 114 +++++++++++
 2 files changed

// File: rtl/binary_maxpool_2x2_if.sv
// Activation stream in, pooled stream out, for the 2x2 binary max-pool stage.
interface binary_maxpool_2x2_if #(
  parameter int unsigned IDX_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             out_valid;
  logic             out_bit;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output clear, in_valid, in_bit,
    input  out_valid, out_bit, out_idx, out_last
  );

  modport slave (
    input  clear, in_valid, in_bit,
    output out_valid, out_bit, out_idx, out_last
  );
endinterface

// File: rtl/binary_maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered 1-bit activation stream.
// On binary activations max reduces to OR; one pooled bit per completed window.
module binary_maxpool_2x2 #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32,
  parameter int unsigned IDX_W = $clog2((IMG_W/2)*(IMG_H/2))
) (
  input  logic                 clk,
  input  logic                 rst,
  binary_maxpool_2x2_if.slave  bus
);

  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned HALF   = IMG_W / 2;
  localparam int unsigned HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned NPOOL  = (IMG_W / 2) * (IMG_H / 2);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [IDX_W-1:0]  pool_q, pool_d;
  logic              h_q, h_d;
  logic [HALF-1:0]   line_buf_q, line_buf_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;

  // Position seen by this cycle's pixel: a clear makes it pixel (0,0).
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [IDX_W-1:0]  cur_pool;
  logic              cur_h;
  logic [HALF_W-1:0] half_idx;
  logic              last_col;
  logic              last_row;

  assign cur_col  = bus.clear ? '0   : col_q;
  assign cur_row  = bus.clear ? '0   : row_q;
  assign cur_pool = bus.clear ? '0   : pool_q;
  assign cur_h    = bus.clear ? 1'b0 : h_q;
  assign half_idx = HALF_W'(cur_col >> 1);
  assign last_col = (cur_col == COL_W'(IMG_W - 1));
  assign last_row = (cur_row == ROW_W'(IMG_H - 1));

  always_comb begin
    col_d       = cur_col;
    row_d       = cur_row;
    pool_d      = cur_pool;
    h_d         = cur_h;
    line_buf_d  = line_buf_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    out_idx_d   = out_idx_q;
    out_last_d  = 1'b0;

    if (bus.in_valid) begin
      // Raster advance
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
      end

      unique case ({cur_row[0], cur_col[0]})
        2'b00: h_d = bus.in_bit;
        2'b01: line_buf_d[half_idx] = cur_h | bus.in_bit;
        2'b10: h_d = bus.in_bit | line_buf_q[half_idx];
        2'b11: begin
          out_valid_d = 1'b1;
          out_bit_d   = cur_h | bus.in_bit;
          out_idx_d   = cur_pool;
          out_last_d  = last_row && last_col;
          pool_d      = (cur_pool == IDX_W'(NPOOL - 1)) ? '0 : cur_pool + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      pool_q      <= '0;
      h_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      pool_q      <= pool_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Top-row ORs need no reset: each even row rewrites them before use.
  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

endmodule
